// File: rtl/ddr_axi_slave_model_if.sv
// ddr_axi_slave_model_if: shared-address-channel DDR AXI bus (A, W, B, R channels)
interface ddr_axi_slave_model_if;
    logic [7:0]   DDR_AID_0;
    logic [31:0]  DDR_AADDR_0;
    logic [7:0]   DDR_ALEN_0;
    logic [2:0]   DDR_ASIZE_0;
    logic [1:0]   DDR_ABURST_0;
    logic [1:0]   DDR_ALOCK_0;
    logic         DDR_AVALID_0;
    logic         DDR_ATYPE_0;
    logic         DDR_AREADY_0;
    logic [7:0]   DDR_WID_0;
    logic [255:0] DDR_WDATA_0;
    logic [31:0]  DDR_WSTRB_0;
    logic         DDR_WLAST_0;
    logic         DDR_WVALID_0;
    logic         DDR_WREADY_0;
    logic [7:0]   DDR_BID_0;
    logic [1:0]   DDR_BRESP_0;
    logic         DDR_BVALID_0;
    logic         DDR_BREADY_0;
    logic [7:0]   DDR_RID_0;
    logic [255:0] DDR_RDATA_0;
    logic [1:0]   DDR_RRESP_0;
    logic         DDR_RLAST_0;
    logic         DDR_RVALID_0;
    logic         DDR_RREADY_0;
    modport slave (
        input  DDR_AID_0, DDR_AADDR_0, DDR_ALEN_0, DDR_ASIZE_0, DDR_ABURST_0, DDR_ALOCK_0,
               DDR_AVALID_0, DDR_ATYPE_0, DDR_WID_0, DDR_WDATA_0, DDR_WSTRB_0, DDR_WLAST_0,
               DDR_WVALID_0, DDR_BREADY_0, DDR_RREADY_0,
        output DDR_AREADY_0, DDR_WREADY_0, DDR_BID_0, DDR_BRESP_0, DDR_BVALID_0,
               DDR_RID_0, DDR_RDATA_0, DDR_RRESP_0, DDR_RLAST_0, DDR_RVALID_0
    );
    modport master (
        output DDR_AID_0, DDR_AADDR_0, DDR_ALEN_0, DDR_ASIZE_0, DDR_ABURST_0, DDR_ALOCK_0,
               DDR_AVALID_0, DDR_ATYPE_0, DDR_WID_0, DDR_WDATA_0, DDR_WSTRB_0, DDR_WLAST_0,
               DDR_WVALID_0, DDR_BREADY_0, DDR_RREADY_0,
        input  DDR_AREADY_0, DDR_WREADY_0, DDR_BID_0, DDR_BRESP_0, DDR_BVALID_0,
               DDR_RID_0, DDR_RDATA_0, DDR_RRESP_0, DDR_RLAST_0, DDR_RVALID_0
    );
endinterface

// File: rtl/ddr_axi_slave_model.sv
// ddr_axi_slave_model: on-chip 256-bit-word AXI responder standing in for the DDR controller
module ddr_axi_slave_model #(
    parameter int MEM_AW = 10
) (
    input  logic                  axi_clk,
    input  logic                  rst,
    input  logic                  i_stall,
    ddr_axi_slave_model_if.slave  ddr,
    output logic                  o_proto_err,
    output logic                  o_busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] WRESP = 2'd2;
    localparam logic [1:0] RDATA = 2'd3;

    logic [1:0]        state;
    logic [7:0]        aid;
    logic [7:0]        alen;
    logic [7:0]        beat;
    logic [MEM_AW-1:0] idx;
    logic [1:0]        code;
    logic              fixed;
    logic [255:0]      mem [0:(1<<MEM_AW)-1];

    logic [MEM_AW-1:0] a_idx;
    logic [MEM_AW-1:0] idx_nxt;
    logic [1:0]        a_code;
    logic              a_hs;
    logic              w_hs;
    logic              r_hs;
    logic              unused_ok;

    assign a_idx   = ddr.DDR_AADDR_0[5+MEM_AW-1:5];
    assign a_code  = (|ddr.DDR_AADDR_0[31:5+MEM_AW]) ? 2'b11 :
                     (ddr.DDR_ASIZE_0 != 3'b101 || ddr.DDR_ABURST_0[1]) ? 2'b10 : 2'b00;
    assign idx_nxt = fixed ? idx : idx + MEM_AW'(1);
    assign a_hs    = state == IDLE  && ddr.DDR_AVALID_0 && ddr.DDR_AREADY_0;
    assign w_hs    = state == WDATA && ddr.DDR_WVALID_0 && ddr.DDR_WREADY_0;
    assign r_hs    = state == RDATA && ddr.DDR_RVALID_0 && ddr.DDR_RREADY_0;
    assign o_busy  = state != IDLE;
    assign unused_ok = ^{ddr.DDR_ALOCK_0, ddr.DDR_WID_0, ddr.DDR_AADDR_0[4:0]};

    // Burst FSM: address capture, beat counting and all registered handshake outputs
    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            aid              <= '0;
            alen             <= '0;
            beat             <= '0;
            idx              <= '0;
            code             <= '0;
            fixed            <= 1'b0;
            o_proto_err      <= 1'b0;
            ddr.DDR_AREADY_0 <= 1'b0;
            ddr.DDR_WREADY_0 <= 1'b0;
            ddr.DDR_BVALID_0 <= 1'b0;
            ddr.DDR_BID_0    <= '0;
            ddr.DDR_BRESP_0  <= '0;
            ddr.DDR_RVALID_0 <= 1'b0;
            ddr.DDR_RDATA_0  <= '0;
            ddr.DDR_RID_0    <= '0;
            ddr.DDR_RRESP_0  <= '0;
            ddr.DDR_RLAST_0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ddr.DDR_AREADY_0 <= !i_stall && !a_hs;
                    if (a_hs) begin
                        aid   <= ddr.DDR_AID_0;
                        alen  <= ddr.DDR_ALEN_0;
                        beat  <= '0;
                        idx   <= a_idx;
                        code  <= a_code;
                        fixed <= ddr.DDR_ABURST_0 == 2'b00;
                        if (ddr.DDR_ATYPE_0) begin
                            state            <= WDATA;
                            ddr.DDR_WREADY_0 <= !i_stall;
                        end else begin
                            state            <= RDATA;
                            ddr.DDR_RVALID_0 <= !i_stall;
                            ddr.DDR_RDATA_0  <= a_code == 2'b00 ? mem[a_idx] : '0;
                            ddr.DDR_RLAST_0  <= ddr.DDR_ALEN_0 == 8'd0;
                            ddr.DDR_RID_0    <= ddr.DDR_AID_0;
                            ddr.DDR_RRESP_0  <= a_code;
                        end
                    end
                end
                WDATA: begin
                    ddr.DDR_WREADY_0 <= !i_stall && !(w_hs && beat == alen);
                    if (w_hs) begin
                        beat <= beat + 8'd1;
                        idx  <= idx_nxt;
                        if (ddr.DDR_WLAST_0 != (beat == alen))
                            o_proto_err <= 1'b1;
                        if (beat == alen) begin
                            state            <= WRESP;
                            ddr.DDR_BVALID_0 <= 1'b1;
                            ddr.DDR_BID_0    <= aid;
                            ddr.DDR_BRESP_0  <= code;
                        end
                    end
                end
                WRESP: begin
                    if (ddr.DDR_BREADY_0) begin
                        ddr.DDR_BVALID_0 <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: begin
                    if (r_hs) begin
                        ddr.DDR_RVALID_0 <= 1'b0;
                        beat             <= beat + 8'd1;
                        idx              <= idx_nxt;
                        if (ddr.DDR_RLAST_0)
                            state <= IDLE;
                    end else if (!ddr.DDR_RVALID_0 && !i_stall) begin
                        ddr.DDR_RVALID_0 <= 1'b1;
                        ddr.DDR_RDATA_0  <= code == 2'b00 ? mem[idx] : '0;
                        ddr.DDR_RLAST_0  <= beat == alen;
                    end
                end
            endcase
        end
    end

    // Byte-strobed memory write; error bursts never touch the array
    always_ff @(posedge axi_clk) begin
        if (w_hs && code == 2'b00)
            for (int i = 0; i < 32; i++)
                if (ddr.DDR_WSTRB_0[i])
                    mem[idx][8*i +: 8] <= ddr.DDR_WDATA_0[8*i +: 8];
    end
endmodule

// File: tb/tb_ddr_axi_slave_model.sv
// tb_ddr_axi_slave_model: directed self-checking bench for the DDR AXI responder
module tb_ddr_axi_slave_model;
    logic axi_clk = 1'b0;
    logic rst = 1'b0;
    logic i_stall = 1'b0;
    logic o_proto_err;
    logic o_busy;
    int checks = 0;
    int failures = 0;
    logic [255:0] wbuf [16];
    logic [255:0] ebuf [16];

    ddr_axi_slave_model_if ddr();

    ddr_axi_slave_model #(.MEM_AW(10)) dut (
        .axi_clk     (axi_clk),
        .rst         (rst),
        .i_stall     (i_stall),
        .ddr         (ddr),
        .o_proto_err (o_proto_err),
        .o_busy      (o_busy)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_addr(input logic t, input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        ddr.DDR_ATYPE_0  = t;
        ddr.DDR_AID_0    = id;
        ddr.DDR_AADDR_0  = addr;
        ddr.DDR_ALEN_0   = len;
        ddr.DDR_ASIZE_0  = size;
        ddr.DDR_ABURST_0 = burst;
        ddr.DDR_AVALID_0 = 1'b1;
        while (!ddr.DDR_AREADY_0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("a_timeout", 0, 1);
        tick();
        ddr.DDR_AVALID_0 = 1'b0;
    endtask

    task automatic wr(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input logic [31:0] strb,
                      input logic [15:0] lastm, input logic [1:0] resp);
        int n;
        do_addr(1'b1, id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            ddr.DDR_WVALID_0 = 1'b1;
            ddr.DDR_WDATA_0  = wbuf[b];
            ddr.DDR_WSTRB_0  = strb;
            ddr.DDR_WLAST_0  = lastm[b];
            n = 0;
            while (!ddr.DDR_WREADY_0 && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) chk("w_timeout", 0, 1);
            tick();
            chk("w_bvalid", ddr.DDR_BVALID_0, b == int'(len));
        end
        ddr.DDR_WVALID_0 = 1'b0;
        ddr.DDR_WLAST_0  = 1'b0;
        ddr.DDR_BREADY_0 = 1'b1;
        n = 0;
        while (!ddr.DDR_BVALID_0 && n < 50) begin
            tick();
            n++;
        end
        chk("b_id", ddr.DDR_BID_0, id);
        chk("b_resp", ddr.DDR_BRESP_0, resp);
        tick();
        chk("b_drop", ddr.DDR_BVALID_0, 0);
        chk("w_idle", o_busy, 0);
        ddr.DDR_BREADY_0 = 1'b0;
    endtask

    task automatic rd(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
        int n;
        do_addr(1'b0, id, addr, len, size, burst);
        chk("r_lat", ddr.DDR_RVALID_0, 1);
        for (int b = 0; b <= int'(len); b++) begin
            ddr.DDR_RREADY_0 = 1'b1;
            n = 0;
            while (!ddr.DDR_RVALID_0 && n < 50) begin
                tick();
                n++;
            end
            chk("r_data", ddr.DDR_RDATA_0, ebuf[b]);
            chk("r_last", ddr.DDR_RLAST_0, b == int'(len));
            chk("r_resp", ddr.DDR_RRESP_0, resp);
            chk("r_id", ddr.DDR_RID_0, id);
            tick();
        end
        ddr.DDR_RREADY_0 = 1'b0;
        chk("r_idle", o_busy, 0);
    endtask

    initial begin
        int got, drops, unstable, order_err, n;
        logic pv, phs, hs;
        logic [255:0] pdata;
        ddr.DDR_AVALID_0 = 1'b0;
        ddr.DDR_ATYPE_0  = 1'b0;
        ddr.DDR_AID_0    = '0;
        ddr.DDR_AADDR_0  = '0;
        ddr.DDR_ALEN_0   = '0;
        ddr.DDR_ASIZE_0  = '0;
        ddr.DDR_ABURST_0 = '0;
        ddr.DDR_ALOCK_0  = '0;
        ddr.DDR_WID_0    = '0;
        ddr.DDR_WVALID_0 = 1'b0;
        ddr.DDR_WDATA_0  = '0;
        ddr.DDR_WSTRB_0  = '0;
        ddr.DDR_WLAST_0  = 1'b0;
        ddr.DDR_BREADY_0 = 1'b0;
        ddr.DDR_RREADY_0 = 1'b0;
        repeat (3) tick();
        chk("rst_aready", ddr.DDR_AREADY_0, 0);
        chk("rst_wready", ddr.DDR_WREADY_0, 0);
        chk("rst_bvalid", ddr.DDR_BVALID_0, 0);
        chk("rst_rvalid", ddr.DDR_RVALID_0, 0);
        chk("rst_perr", o_proto_err, 0);
        chk("rst_busy", o_busy, 0);
        rst = 1'b1;
        tick();
        chk("aready_rise", ddr.DDR_AREADY_0, 1);

        for (int b = 0; b < 5; b++) wbuf[b] = {32{8'(b)}};
        wr(8'h5A, 32'h40, 8'd4, 3'd5, 2'b01, '1, 16'h0010, 2'b00);
        for (int b = 0; b < 5; b++) ebuf[b] = {32{8'(b)}};
        rd(8'h3C, 32'h40, 8'd4, 3'd5, 2'b01, 2'b00);

        wbuf[0] = '1;
        wr(8'h01, 32'h0, 8'd0, 3'd5, 2'b01, '1, 16'h0001, 2'b00);
        wbuf[0] = '0;
        wr(8'h02, 32'h0, 8'd0, 3'd5, 2'b01, 32'h0000_0001, 16'h0001, 2'b00);
        ebuf[0] = {{31{8'hFF}}, 8'h00};
        rd(8'h03, 32'h0, 8'd0, 3'd5, 2'b01, 2'b00);

        wbuf[0] = {32{8'hAA}};
        wbuf[1] = {32{8'hAA}};
        wr(8'h04, 32'h0010_0000, 8'd1, 3'd5, 2'b01, '1, 16'h0002, 2'b11);
        ebuf[0] = '0;
        ebuf[1] = '0;
        rd(8'h05, 32'h0010_0000, 8'd1, 3'd5, 2'b01, 2'b11);
        ebuf[0] = {{31{8'hFF}}, 8'h00};
        rd(8'h06, 32'h0, 8'd0, 3'd5, 2'b01, 2'b00);

        wbuf[0] = {32{8'h77}};
        wr(8'h07, 32'h40, 8'd0, 3'd4, 2'b01, '1, 16'h0001, 2'b10);
        ebuf[0] = '0;
        rd(8'h08, 32'h40, 8'd0, 3'd4, 2'b01, 2'b10);
        rd(8'h09, 32'h40, 8'd0, 3'd5, 2'b01, 2'b00);

        for (int b = 0; b < 4; b++) wbuf[b] = {32{8'(8'h11 * (b + 1))}};
        wr(8'h0A, 32'h140, 8'd3, 3'd5, 2'b00, '1, 16'h0008, 2'b00);
        ebuf[0] = {32{8'h44}};
        ebuf[1] = {32{8'h44}};
        rd(8'h0B, 32'h140, 8'd1, 3'd5, 2'b00, 2'b00);

        for (int b = 0; b < 4; b++) wbuf[b] = {32{8'(8'hA0 + b)}};
        wr(8'h0C, 32'h7FC0, 8'd3, 3'd5, 2'b01, '1, 16'h0008, 2'b00);
        for (int b = 0; b < 4; b++) ebuf[b] = {32{8'(8'hA0 + b)}};
        rd(8'h0D, 32'h7FC0, 8'd3, 3'd5, 2'b01, 2'b00);
        ebuf[0] = {32{8'hA2}};
        rd(8'h0E, 32'h0, 8'd0, 3'd5, 2'b01, 2'b00);

        for (int b = 0; b < 16; b++) wbuf[b] = {8{32'(b * 7 + 3)}};
        wr(8'h10, 32'hC80, 8'd15, 3'd5, 2'b01, '1, 16'h8000, 2'b00);
        for (int b = 0; b < 16; b++) ebuf[b] = {8{32'(b * 7 + 3)}};
        do_addr(1'b0, 8'h11, 32'hC80, 8'd15, 3'd5, 2'b01);
        got = 0; drops = 0; unstable = 0; order_err = 0; n = 0;
        pv = 1'b0; phs = 1'b0; pdata = '0;
        while (got < 16 && n < 400) begin
            if (pv && !phs && !ddr.DDR_RVALID_0) drops++;
            if (pv && !phs && ddr.DDR_RVALID_0 && ddr.DDR_RDATA_0 !== pdata) unstable++;
            ddr.DDR_RREADY_0 = 1'($urandom_range(0, 1));
            i_stall = 1'($urandom_range(0, 1));
            hs = ddr.DDR_RVALID_0 && ddr.DDR_RREADY_0;
            if (hs) begin
                if (ddr.DDR_RDATA_0 !== ebuf[got] || ddr.DDR_RLAST_0 !== (got == 15)) order_err++;
                got++;
            end
            pv = ddr.DDR_RVALID_0;
            phs = hs;
            pdata = ddr.DDR_RDATA_0;
            tick();
            n++;
        end
        ddr.DDR_RREADY_0 = 1'b0;
        i_stall = 1'b0;
        chk("bp_beats", got, 16);
        chk("bp_drops", drops, 0);
        chk("bp_stable", unstable, 0);
        chk("bp_order", order_err, 0);
        tick();

        chk("perr_clean", o_proto_err, 0);
        for (int b = 0; b < 4; b++) wbuf[b] = {32{8'h5C}};
        wr(8'h14, 32'h200, 8'd3, 3'd5, 2'b01, '1, 16'h0002, 2'b00);
        chk("perr_set", o_proto_err, 1);

        do_addr(1'b0, 8'h21, 32'hC80, 8'd7, 3'd5, 2'b01);
        chk("mid_rvalid", ddr.DDR_RVALID_0, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_rvalid", ddr.DDR_RVALID_0, 0);
        chk("mid_rst_aready", ddr.DDR_AREADY_0, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_perr", o_proto_err, 0);
        @(posedge axi_clk);
        #1 rst = 1'b1;
        tick();
        chk("rel_aready", ddr.DDR_AREADY_0, 1);
        ebuf[0] = {8{32'd3}};
        rd(8'h22, 32'hC80, 8'd0, 3'd5, 2'b01, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ddr_axi_slave_model.md
# ddr_axi_slave_model

Synthesizable AXI responder for the shared-address-channel DDR interface (single A channel qualified by `DDR_ATYPE_0`). It stands in for the DDR controller so the UART→DDR write path and the readback/compare path can be exercised on FPGA and in simulation without a hard memory controller. Backing store is an on-chip array of 256-bit words that accepts one burst at a time. Write strobes, INCR/FIXED bursts, error responses and injected back-pressure are supported.

## Interface
- `MEM_AW`, 10: log2 of memory depth in 256-bit words (default 1024 words = 32 KiB).
- `axi_clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-low.
- `i_stall` in 1: back-pressure injection. Gates new AREADY, WREADY and RVALID assertions.
- `DDR_AID_0` in 8, `DDR_AADDR_0` in 32, `DDR_ALEN_0` in 8, `DDR_ASIZE_0` in 3, `DDR_ABURST_0` in 2, `DDR_ALOCK_0` in 2 (ignored), `DDR_AVALID_0` in 1, `DDR_ATYPE_0` in 1: address channel inputs. `DDR_ATYPE_0`: 1 = write, 0 = read.
- `DDR_AREADY_0` out 1: address accept.
- `DDR_WID_0` in 8 (ignored), `DDR_WDATA_0` in 256, `DDR_WSTRB_0` in 32, `DDR_WLAST_0` in 1, `DDR_WVALID_0` in 1: write data inputs.
- `DDR_WREADY_0` out 1: write data accept.
- `DDR_BID_0` out 8, `DDR_BRESP_0` out 2, `DDR_BVALID_0` out 1: write response outputs.
- `DDR_BREADY_0` in 1: write response ready.
- `DDR_RID_0` out 8, `DDR_RDATA_0` out 256, `DDR_RRESP_0` out 2, `DDR_RLAST_0` out 1, `DDR_RVALID_0` out 1: read data outputs.
- `DDR_RREADY_0` in 1: read data ready.
- `o_proto_err` out 1: sticky flag, WLAST mismatch.
- `o_busy` out 1: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: AREADY = registered `!i_stall`. On `AVALID&&AREADY`, capture AID, ALEN, start index and response code, then go to WDATA (ATYPE=1) or RDATA (ATYPE=0).
  - WDATA → WRESP after the (ALEN+1)th W handshake.
  - WRESP → IDLE on `BVALID&&BREADY`.
  - RDATA → IDLE on the last R handshake.
- Index: start = `AADDR[5+MEM_AW-1:5]`. `AADDR[4:0]` is ignored.
  - INCR (`ABURST=01`): index increments by one per beat and wraps modulo 2^MEM_AW.
  - FIXED (`ABURST=00`): index is held for the whole burst.
- Response code, fixed at address accept:
  - DECERR (11) if `AADDR[31:5+MEM_AW]≠0`.
  - Otherwise SLVERR (10) if `ASIZE≠3'b101` or `ABURST∈{10,11}`.
  - Otherwise OKAY (00).
  - Only the start address is range-checked.
- Non-OKAY bursts still run the full beat count. Writes are suppressed and read data is all-zero.
- Writes: each W handshake updates `mem[idx]` byte *i* from `WDATA[8i+7:8i]` only where `WSTRB[i]=1`.
- Beat counting: an 8-bit beat counter decides the last beat, not WLAST.
  - If WLAST ≠ (beat==ALEN) on any handshake, `o_proto_err` sets and stays set until reset.
- Reads: each beat drives RDATA = `mem[idx]`, RID = captured AID, RRESP = captured code, RLAST = (beat==ALEN).
- Memory contents are not reset.

## Timing
- Reset values: every output 0, state IDLE.
- AREADY rises the first edge after reset release (if `!i_stall`). It drops on the accepting edge and re-rises no earlier than one cycle after returning to IDLE.
- WREADY:
  - Registered and follows `!i_stall` with a 1-cycle lag while in WDATA.
  - First possible assertion is the cycle after address accept. W beats arriving before the address stall.
  - Drops on the edge accepting the last beat.
- Write response:
  - BVALID asserts the cycle after the last W handshake, with BID = captured AID and BRESP = captured code.
  - It holds until BREADY. BVALID drops on the handshake edge, and state returns to IDLE on that same edge.
- Read data:
  - Beat 0 RVALID asserts the cycle after address accept (if `!i_stall`).
  - After each handshake, the next beat presents the following cycle if `!i_stall`, giving at most one beat per 2 cycles. Back-to-back beats are not required.
  - RDATA, RLAST, RRESP and RID are stable while `RVALID&&!RREADY`.
- `i_stall` never retracts an asserted AREADY-captured transfer, RVALID or BVALID. It only delays new assertions.
- Reset asserted mid-burst: outputs go to reset values immediately, the burst is abandoned, and the memory retains any beats already written.
- Simultaneous AVALID and WVALID in IDLE: the address is accepted first. The W beat waits for WREADY.

## Test plan
- Write burst then read back:
  - Write AADDR=0x40, ALEN=4, ASIZE=5, INCR; WDATA = beat number replicated; WSTRB=all-ones → BRESP=00, BID=AID.
  - Read the same address with ALEN=4 → 5 beats at words 2..6 returning 0..4, RLAST only on beat 4.
- Partial strobe: write 0xFF..FF to word 0, then WSTRB=0x0000_0001 with data 0 → readback byte 0 = 0x00, bytes 1..31 = 0xFF.
- Errors:
  - AADDR=0x0010_0000 (MEM_AW=10) → DECERR on all beats, memory unchanged.
  - ASIZE=4 → SLVERR.
  - ABURST=00 with ALEN=3 writes to a single word; the last beat wins.
- Wrap: INCR write at word 1022 with ALEN=3 → words 1022, 1023, 0, 1 are written.
- Back-pressure: toggle `i_stall` and RREADY randomly across a 16-beat read → every beat arrives in order, RVALID never drops without a handshake, and no data is lost.
- Protocol and reset:
  - WLAST on beat 1 of an ALEN=3 burst → `o_proto_err`=1 and the burst still completes after 4 beats.
  - Reset mid-read → RVALID=0 and AREADY re-asserts the cycle after release.
